bsg_fpu_classify_arb: RTL
=========================

# bsg_fpu_classify_arb

Shares one `bsg_fpu_preprocess` classifier among `els_p` requesters, such as FPU lanes and the CSR/debug path. The block arbitrates round-robin and converts the preprocess flags into a RISC-V `fclass` 10-bit one-hot mask. The result is held in a one-entry output register with a valid/yumi handshake. It sits between the issue logic and the integer writeback of the FP classify/compare path.

## Interface
Parameters:
- `e_p`, 11, exponent width
- `m_p`, 52, mantissa width
- `els_p`, 4, number of requesters (≥2)
- `ctr_width_p`, 16, grant-counter width (used only when the perf feature is enabled)

Ports (one clock; reset is asynchronous and active-high):
- `clk_i`  in  1  clock
- `reset_i`  in  1  asynchronous active-high reset
- `v_i`  in  els_p  per-requester valid
- `a_i`  in  els_p×(e_p+m_p+1)  per-requester operand; `{sign, exp, man}`
- `ready_o`  out  els_p  per-requester accept; one-hot or zero
- `v_o`  out  1  output register holds a result
- `class_o`  out  10  fclass one-hot mask
- `id_o`  out  ⌈log2(els_p)⌉  requester index of the held result
- `yumi_i`  in  1  consumer takes the result this cycle; legal only when `v_o`=1
- `grant_count_o`  out  els_p×ctr_width_p  per-requester grant counts; present only with `BSG_FPU_CLASSIFY_ARB_PERF_EN`

## Operation
- **Transfer.** A transfer on requester i occurs when `v_i[i] & ready_o[i]`.
- **Accept condition.** `ready_o[w]`=1 only for the arbitration winner w, and only when `~v_o | yumi_i`. Otherwise `ready_o`=0.
- **Round-robin order.** The requester after the last granted one has highest priority; the order then wraps modulo `els_p`. After reset, requester 0 has highest priority. The pointer advances only on a transfer.
- **Combinational path.** The winner's operand is muxed into a single `bsg_fpu_preprocess` instance. The fclass mask is formed from its flags before the output register.
- **fclass bit encoding:**
  - 0: −inf
  - 1: −normal
  - 2: −subnormal
  - 3: −zero
  - 4: +zero
  - 5: +subnormal
  - 6: +normal
  - 7: +inf
  - 8: sNaN
  - 9: qNaN
- **fclass rules:**
  - Normal means exponent neither all-zero nor all-one.
  - sNaN is a NaN with mantissa MSB=0; qNaN has mantissa MSB=1.
  - NaN ignores the sign bit.
  - Exactly one bit is set per result.
- **Output register.** On a transfer, the register loads `class_o` and `id_o`, and `v_o` is set.
- **Dequeue.** On `yumi_i` with no simultaneous transfer, `v_o` clears.
- **Simultaneous `yumi_i` and transfer.** The register reloads and `v_o` stays 1, giving one result per cycle.
- **Inputs while not ready.** An input with `v_i` high but not ready is not consumed. Requesters must hold `a_i` stable until accepted.
- **`yumi_i` while `v_o`=0.** This is illegal; the bench asserts on it, and the design ignores it.

## Timing
- Latency is 1 cycle: accept at edge N means `v_o`=1 and results are valid after edge N.
- Full throughput: one result per cycle when `yumi_i` is held high.
- `ready_o` depends combinationally on `v_i` and `yumi_i`. No other input-to-output combinational paths exist.
- **Reset values:**
  - `v_o`=0, `class_o`=0, `id_o`=0
  - round-robin pointer → requester 0 highest priority
  - counters = 0
- **Reset mid-operation:** any held result is discarded immediately, asynchronously. `ready_o` is 0 while `reset_i` is high.
- **Backpressure:** while `v_o`=1 and `yumi_i`=0:
  - `class_o` and `id_o` are held stable
  - all `ready_o` are 0
  - the pointer is unchanged

## Configuration
- **`BSG_FPU_CLASSIFY_ARB_PERF_EN` defined:**
  - The `grant_count_o` port exists.
  - Counter i increments by 1 on each transfer from requester i.
  - Each counter saturates at all-ones.
  - All counters reset to 0.
- **Not defined:** the port and the counters are absent, with no other behavioural change.

## Structure
- **Package `bsg_fpu_classify_pkg`:**
  - fclass bit-index constants, e.g. `fclass_neg_inf_gp` … `fclass_qnan_gp`
  - `fclass_width_gp`=10
- **Sub-module `bsg_fpu_classify_rr`:** round-robin arbiter holding the pointer. Inputs are `reqs`, `advance` and enable; outputs are the one-hot grant and the encoded index.
- **Top level:** instantiates `bsg_fpu_classify_rr` and one `bsg_fpu_preprocess`, plus the fclass encode logic and the output register.

## Test plan
- **Single-requester encoding.** Requester 0 sends the following, with `yumi_i`=1; each must appear with `id_o`=0 one cycle later:

  | Operand | `class_o` | Class |
  |---|---|---|
  | 0x7FF0000000000000 | 0x080 | +inf |
  | 0x7FF8000000000000 | 0x200 | qNaN |
  | 0x7FF0000000000001 | 0x100 | sNaN |
  | 0x8000000000000000 | 0x008 | −zero |
  | 0x0000000000000001 | 0x020 | +subnormal |
  | 0xBFF0000000000000 | 0x002 | −normal |

- **Round-robin fairness.** All 4 `v_i` are held high with `yumi_i`=1 → `id_o` sequence 0,1,2,3,0,1. Each `ready_o` is one-hot, and results are back-to-back.
- **Backpressure.** `v_o`=1 with `yumi_i`=0 for 5 cycles → `class_o`/`id_o` stable and `ready_o`=0. When `yumi_i` rises with requester 2 pending, the next cycle shows `id_o`=2.
- **Reset mid-operation.** Pulse `reset_i` while `v_o`=1 → `v_o`=0 immediately. After reset with requesters 1 and 3 valid, requester 1 is granted first.
- **Perf counters (`BSG_FPU_CLASSIFY_ARB_PERF_EN`):**
  - 10 transfers from requester 3 → `grant_count_o[3]`=10, others 0.
  - With `ctr_width_p`=4 and 20 transfers → the count saturates at 15.

Source files
------------

// File: rtl/bsg_fpu_classify_pkg.sv
// ============================================================================
// Module   : bsg_fpu_classify_pkg
// Brief    : Shared constants for the fclass arbiter: mask width and the bit
//            index of each RISC-V fclass category.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bsg_fpu_classify_pkg;

  localparam int fclass_width_gp    = 10;

  localparam int fclass_neg_inf_gp  = 0;
  localparam int fclass_neg_norm_gp = 1;
  localparam int fclass_neg_sub_gp  = 2;
  localparam int fclass_neg_zero_gp = 3;
  localparam int fclass_pos_zero_gp = 4;
  localparam int fclass_pos_sub_gp  = 5;
  localparam int fclass_pos_norm_gp = 6;
  localparam int fclass_pos_inf_gp  = 7;
  localparam int fclass_snan_gp     = 8;
  localparam int fclass_qnan_gp     = 9;

endpackage

`default_nettype wire

// File: rtl/bsg_fpu_classify_rr.sv
// ============================================================================
// Module   : bsg_fpu_classify_rr
// Brief    : Round-robin arbiter. Priority starts just after the last granted
//            requester and wraps; the pointer moves only when told a grant
//            was actually consumed.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bsg_fpu_classify_rr #(
  parameter int els_p = 4,
  localparam int id_width_lp = $clog2(els_p)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [els_p-1:0]       i_reqs,
  input  logic                   i_en,
  input  logic                   i_advance,
  output logic [els_p-1:0]       o_grant,
  output logic [id_width_lp-1:0] o_idx
);

  logic [id_width_lp-1:0] r_last;
  logic [id_width_lp:0]   w_sum;
  logic                   w_found;
  logic [els_p-1:0]       w_grant;
  logic [id_width_lp-1:0] w_idx;

  // Scan candidates in priority order starting at r_last+1, first request wins.
  always_comb begin
    w_sum   = '0;
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = 1; k <= els_p; k++) begin
      w_sum = {1'b0, r_last} + (id_width_lp+1)'(k);
      if (w_sum >= (id_width_lp+1)'(els_p)) begin
        w_sum = w_sum - (id_width_lp+1)'(els_p);
      end
      if (!w_found && i_reqs[w_sum[id_width_lp-1:0]]) begin
        w_found                          = 1'b1;
        w_grant[w_sum[id_width_lp-1:0]]  = 1'b1;
        w_idx                            = w_sum[id_width_lp-1:0];
      end
    end
  end

  assign o_grant = i_en ? w_grant : '0;
  assign o_idx   = w_idx;

  // Pointer holds the last granted index; resetting to els_p-1 puts 0 first.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_last <= id_width_lp'(els_p - 1);
    end else if (i_advance) begin
      r_last <= w_idx;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bsg_fpu_preprocess.sv
// ============================================================================
// Module   : bsg_fpu_preprocess
// Brief    : Decodes an IEEE-754 operand {sign, exp, man} into category flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bsg_fpu_preprocess #(
  parameter int e_p = 11,
  parameter int m_p = 52
) (
  input  logic [e_p+m_p:0] a_i,
  output logic             zero_o,
  output logic             nan_o,
  output logic             sig_nan_o,
  output logic             infty_o,
  output logic             denormal_o,
  output logic             sign_o
);

  logic [e_p-1:0] w_exp;
  logic [m_p-1:0] w_man;
  logic           w_exp_zero;
  logic           w_exp_ones;
  logic           w_man_zero;

  assign w_exp      = a_i[m_p +: e_p];
  assign w_man      = a_i[m_p-1:0];
  assign w_exp_zero = (w_exp == '0);
  assign w_exp_ones = (w_exp == '1);
  assign w_man_zero = (w_man == '0);

  assign sign_o     = a_i[e_p+m_p];
  assign zero_o     = w_exp_zero &  w_man_zero;
  assign denormal_o = w_exp_zero & ~w_man_zero;
  assign infty_o    = w_exp_ones &  w_man_zero;
  assign nan_o      = w_exp_ones & ~w_man_zero;
  // Quiet bit is the mantissa MSB; a NaN without it is signaling.
  assign sig_nan_o  = nan_o & ~w_man[m_p-1];

endmodule

`default_nettype wire

// File: rtl/bsg_fpu_classify_arb.sv
// ============================================================================
// Module   : bsg_fpu_classify_arb
// Brief    : Shares one fclass classifier among els_p requesters with
//            round-robin arbitration and a one-entry valid/yumi output stage.
//            Optional per-requester grant counters are built when the macro
//            BSG_FPU_CLASSIFY_ARB_PERF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bsg_fpu_classify_arb
  import bsg_fpu_classify_pkg::*;
#(
  parameter int e_p         = 11,
  parameter int m_p         = 52,
  parameter int els_p       = 4,
  parameter int ctr_width_p = 16,
  localparam int w_lp       = e_p + m_p + 1,
  localparam int id_width_lp = $clog2(els_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [els_p-1:0]           v_i,
  input  logic [els_p*w_lp-1:0]      a_i,
  output logic [els_p-1:0]           ready_o,
  output logic                       v_o,
  output logic [fclass_width_gp-1:0] class_o,
  output logic [id_width_lp-1:0]     id_o,
`ifdef BSG_FPU_CLASSIFY_ARB_PERF_EN
  output logic [els_p*ctr_width_p-1:0] grant_count_o,
`endif
  input  logic                       yumi_i
);

  logic [els_p-1:0]           w_grant;
  logic [id_width_lp-1:0]     w_idx;
  logic                       w_en;
  logic                       w_xfer;
  logic [w_lp-1:0]            w_opnd;
  logic                       w_zero, w_nan, w_snan, w_inf, w_sub, w_sign;
  logic [fclass_width_gp-1:0] w_class;
  logic                       r_v;
  logic [fclass_width_gp-1:0] r_class;
  logic [id_width_lp-1:0]     r_id;

  // The output slot is free when empty or being drained this cycle.
  assign w_en   = ~reset_i & (~r_v | yumi_i);
  assign w_xfer = |w_grant;

  bsg_fpu_classify_rr #(.els_p(els_p)) u_rr (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .i_reqs    (v_i),
    .i_en      (w_en),
    .i_advance (w_xfer),
    .o_grant   (w_grant),
    .o_idx     (w_idx)
  );

  assign ready_o = w_grant;
  assign w_opnd  = a_i[w_idx*w_lp +: w_lp];

  bsg_fpu_preprocess #(.e_p(e_p), .m_p(m_p)) u_pre (
    .a_i        (w_opnd),
    .zero_o     (w_zero),
    .nan_o      (w_nan),
    .sig_nan_o  (w_snan),
    .infty_o    (w_inf),
    .denormal_o (w_sub),
    .sign_o     (w_sign)
  );

  // Turn the preprocess flags into a one-hot fclass mask; NaN ignores sign.
  always_comb begin
    w_class = '0;
    if (w_nan) begin
      if (w_snan) w_class[fclass_snan_gp] = 1'b1;
      else        w_class[fclass_qnan_gp] = 1'b1;
    end else if (w_inf) begin
      if (w_sign) w_class[fclass_neg_inf_gp] = 1'b1;
      else        w_class[fclass_pos_inf_gp] = 1'b1;
    end else if (w_zero) begin
      if (w_sign) w_class[fclass_neg_zero_gp] = 1'b1;
      else        w_class[fclass_pos_zero_gp] = 1'b1;
    end else if (w_sub) begin
      if (w_sign) w_class[fclass_neg_sub_gp] = 1'b1;
      else        w_class[fclass_pos_sub_gp] = 1'b1;
    end else begin
      if (w_sign) w_class[fclass_neg_norm_gp] = 1'b1;
      else        w_class[fclass_pos_norm_gp] = 1'b1;
    end
  end

  // One-entry result register: load on transfer, clear on a bare dequeue.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_v     <= 1'b0;
      r_class <= '0;
      r_id    <= '0;
    end else if (w_xfer) begin
      r_v     <= 1'b1;
      r_class <= w_class;
      r_id    <= w_idx;
    end else if (yumi_i) begin
      r_v     <= 1'b0;
    end
  end

  assign v_o     = r_v;
  assign class_o = r_class;
  assign id_o    = r_id;

`ifdef BSG_FPU_CLASSIFY_ARB_PERF_EN
  for (genvar g = 0; g < els_p; g++) begin : g_ctr
    logic [ctr_width_p-1:0] r_cnt;
    // Saturating count of transfers granted to this requester.
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        r_cnt <= '0;
      end else if (w_grant[g] && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
    assign grant_count_o[g*ctr_width_p +: ctr_width_p] = r_cnt;
  end
`endif

endmodule

`default_nettype wire
